// File: rtl/pe_pair_sched_if.sv
// ----------------------------------------------------------------------------
// pe_pair_sched_if
// Handshake/bus bundle between the pair scheduler and its surroundings
// (ESN step control, weight ROM, hybrid PE, state buffer).
// Signal names carry the scheduler's point of view (_i = into the scheduler,
// _o = out of the scheduler).
//   start_i    begin a run (pulse, sampled in IDLE)
//   abort_i    synchronous abort of the current run
//   wt_rdy_i   weight memory accepts an address this cycle
//   pe_q_i     PE output bus, 2*WWORD_LEN
//   busy_o     run in progress
//   done_o     one-cycle pulse after the last write-back
//   wt_addr_o  pair index being issued
//   pe_ce_o    PE output register enable
//   res_we_o   state-buffer write strobe
//   res_addr_o pair index of the result being written
//   res_data_o PE result pass-through
// Modports: master = scheduler side, slave = control/datapath side.
// ----------------------------------------------------------------------------
interface pe_pair_sched_if #(
  parameter int AW        = 2,
  parameter int WWORD_LEN = 32
);
  logic                   start_i;
  logic                   abort_i;
  logic                   wt_rdy_i;
  logic [2*WWORD_LEN-1:0] pe_q_i;
  logic                   busy_o;
  logic                   done_o;
  logic [AW-1:0]          wt_addr_o;
  logic                   pe_ce_o;
  logic                   res_we_o;
  logic [AW-1:0]          res_addr_o;
  logic [2*WWORD_LEN-1:0] res_data_o;

  modport master (
    input  start_i, abort_i, wt_rdy_i, pe_q_i,
    output busy_o, done_o, wt_addr_o, pe_ce_o, res_we_o, res_addr_o, res_data_o
  );

  modport slave (
    output start_i, abort_i, wt_rdy_i, pe_q_i,
    input  busy_o, done_o, wt_addr_o, pe_ce_o, res_we_o, res_addr_o, res_data_o
  );
endinterface

// File: rtl/pe_pair_sched.sv
// ----------------------------------------------------------------------------
// pe_pair_sched
// Sequences one reservoir time-step through a single 8-in/2-out hybrid PE:
// issues NPAIRS pair evaluations, tracks each through the fixed PE_LAT-cycle
// PE pipeline and writes each 2-word result back to the state buffer.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        pe_pair_sched_if.master (handshake, weight address, PE ce,
//              result write port)
//   cyc_cnt_o  busy-cycle counter, 16 bit saturating; present only when the
//              macro PESCHED_CYCCNT_EN is defined
// ----------------------------------------------------------------------------
module pe_pair_sched #(
  parameter int NPAIRS    = 4,
  parameter int PE_LAT    = 3,
  parameter int AW        = 2,
  parameter int WWORD_LEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PESCHED_CYCCNT_EN
  output logic [15:0]       cyc_cnt_o,
`endif
  pe_pair_sched_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NPAIRS - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [PE_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]     tag_q [PE_LAT];
  logic [AW-1:0]     tag_d [PE_LAT];
  logic              busy_q, done_q;
  logic              push, kill, run_start;

  always_comb begin
    run_start = (state_q == S_IDLE) && bus.start_i && !bus.abort_i;
    kill      = (state_q != S_IDLE) && bus.abort_i;
    push      = (state_q == S_ISSUE) && bus.wt_rdy_i && !bus.abort_i;

    // Pipe shifts every cycle; a stalled issue enters as a bubble.
    vld_d[0] = push;
    tag_d[0] = idx_q;
    for (int i = 1; i < PE_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    if (kill) vld_d = '0;

    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (run_start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (kill) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (push) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Leave once the entry now at the pipe tail is the last one.
        if (kill)              state_d = S_IDLE;
        else if (vld_d == '0)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < PE_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      for (int i = 0; i < PE_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.pe_ce_o    = busy_q;
  assign bus.done_o     = done_q;
  assign bus.wt_addr_o  = idx_q;
  assign bus.res_we_o   = vld_q[PE_LAT-1];
  assign bus.res_addr_o = tag_q[PE_LAT-1];
  assign bus.res_data_o = bus.pe_q_i;

`ifdef PESCHED_CYCCNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cyc_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cyc_cnt_q <= '0;
    else if (run_start) cyc_cnt_q <= '0;
    else if (busy_q)    cyc_cnt_q <= sat_inc16(cyc_cnt_q);
  end

  assign cyc_cnt_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_pe_pair_sched.sv
// ----------------------------------------------------------------------------
// tb_pe_pair_sched
// Directed bench for pe_pair_sched (NPAIRS=4, PE_LAT=3, AW=2, WWORD_LEN=32).
// Cycle 0 is the cycle in which start is driven; all expectations are
// hand-written per cycle. PESCHED_CYCCNT_EN enables the counter scenario.
// ----------------------------------------------------------------------------
module tb_pe_pair_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

`ifdef PESCHED_CYCCNT_EN
  logic [15:0] cyc_cnt;
`endif

  pe_pair_sched_if #(.AW(2), .WWORD_LEN(32)) bus ();

  pe_pair_sched #(.NPAIRS(4), .PE_LAT(3), .AW(2), .WWORD_LEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef PESCHED_CYCCNT_EN
    .cyc_cnt_o (cyc_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input bit ab, input bit rdy, input int c);
    bus.start_i  = st;
    bus.abort_i  = ab;
    bus.wt_rdy_i = rdy;
    bus.pe_q_i   = {32'(c + 1), 32'hC0DE0000 | 32'(c)};
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    tick(); tick();
    vec_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset busy got %0b exp 0", bus.busy_o); end
    vec_cnt++; if (bus.done_o !== 1'b0) begin err_cnt++; $display("FAIL reset done got %0b exp 0", bus.done_o); end
    vec_cnt++; if (bus.pe_ce_o !== 1'b0) begin err_cnt++; $display("FAIL reset pe_ce got %0b exp 0", bus.pe_ce_o); end
    vec_cnt++; if (bus.res_we_o !== 1'b0) begin err_cnt++; $display("FAIL reset res_we got %0b exp 0", bus.res_we_o); end
    vec_cnt++; if (bus.wt_addr_o !== 2'd0) begin err_cnt++; $display("FAIL reset wt_addr got %0d exp 0", bus.wt_addr_o); end
    vec_cnt++; if (bus.res_addr_o !== 2'd0) begin err_cnt++; $display("FAIL reset res_addr got %0d exp 0", bus.res_addr_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit eb[10] = '{0,1,1,1,1,1,1,1,0,0};
    bit ed[10] = '{0,0,0,0,0,0,0,0,1,0};
    bit ew[10] = '{0,0,0,0,1,1,1,1,0,0};
    int er[10] = '{0,0,0,0,0,1,2,3,0,0};
    int ea[10] = '{0,0,1,2,3,-1,-1,-1,-1,-1};
    for (int c = 0; c < 10; c++) begin
      drive(c == 0, 0, 1, c);
      vec_cnt++; if (bus.busy_o !== eb[c]) begin err_cnt++; $display("FAIL basic busy c%0d got %0b exp %0b", c, bus.busy_o, eb[c]); end
      vec_cnt++; if (bus.pe_ce_o !== eb[c]) begin err_cnt++; $display("FAIL basic pe_ce c%0d got %0b exp %0b", c, bus.pe_ce_o, eb[c]); end
      vec_cnt++; if (bus.done_o !== ed[c]) begin err_cnt++; $display("FAIL basic done c%0d got %0b exp %0b", c, bus.done_o, ed[c]); end
      vec_cnt++; if (bus.res_we_o !== ew[c]) begin err_cnt++; $display("FAIL basic res_we c%0d got %0b exp %0b", c, bus.res_we_o, ew[c]); end
      if (ew[c]) begin
        vec_cnt++; if (bus.res_addr_o !== 2'(er[c])) begin err_cnt++; $display("FAIL basic res_addr c%0d got %0d exp %0d", c, bus.res_addr_o, er[c]); end
        vec_cnt++; if (bus.res_data_o !== {32'(c + 1), 32'hC0DE0000 | 32'(c)}) begin err_cnt++; $display("FAIL basic res_data c%0d got %h", c, bus.res_data_o); end
      end
      if (ea[c] >= 0) begin
        vec_cnt++; if (bus.wt_addr_o !== 2'(ea[c])) begin err_cnt++; $display("FAIL basic wt_addr c%0d got %0d exp %0d", c, bus.wt_addr_o, ea[c]); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    bit eb[11] = '{0,1,1,1,1,1,1,1,1,0,0};
    bit ed[11] = '{0,0,0,0,0,0,0,0,0,1,0};
    bit ew[11] = '{0,0,0,0,1,0,1,1,1,0,0};
    int er[11] = '{0,0,0,0,0,0,1,2,3,0,0};
    int ea[11] = '{0,0,1,1,2,3,-1,-1,-1,-1,-1};
    for (int c = 0; c < 11; c++) begin
      drive(c == 0, 0, c != 2, c);
      vec_cnt++; if (bus.busy_o !== eb[c]) begin err_cnt++; $display("FAIL stall busy c%0d got %0b exp %0b", c, bus.busy_o, eb[c]); end
      vec_cnt++; if (bus.done_o !== ed[c]) begin err_cnt++; $display("FAIL stall done c%0d got %0b exp %0b", c, bus.done_o, ed[c]); end
      vec_cnt++; if (bus.res_we_o !== ew[c]) begin err_cnt++; $display("FAIL stall res_we c%0d got %0b exp %0b", c, bus.res_we_o, ew[c]); end
      if (ew[c]) begin
        vec_cnt++; if (bus.res_addr_o !== 2'(er[c])) begin err_cnt++; $display("FAIL stall res_addr c%0d got %0d exp %0d", c, bus.res_addr_o, er[c]); end
      end
      if (ea[c] >= 0) begin
        vec_cnt++; if (bus.wt_addr_o !== 2'(ea[c])) begin err_cnt++; $display("FAIL stall wt_addr c%0d got %0d exp %0d", c, bus.wt_addr_o, ea[c]); end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    bit eb[9] = '{0,1,1,1,1,1,0,0,0};
    bit ew[9] = '{0,0,0,0,1,1,0,0,0};
    int er[9] = '{0,0,0,0,0,1,0,0,0};
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, c == 5, 1, c);
      vec_cnt++; if (bus.busy_o !== eb[c]) begin err_cnt++; $display("FAIL abort busy c%0d got %0b exp %0b", c, bus.busy_o, eb[c]); end
      vec_cnt++; if (bus.done_o !== 1'b0) begin err_cnt++; $display("FAIL abort done c%0d got %0b exp 0", c, bus.done_o); end
      vec_cnt++; if (bus.res_we_o !== ew[c]) begin err_cnt++; $display("FAIL abort res_we c%0d got %0b exp %0b", c, bus.res_we_o, ew[c]); end
      if (ew[c]) begin
        vec_cnt++; if (bus.res_addr_o !== 2'(er[c])) begin err_cnt++; $display("FAIL abort res_addr c%0d got %0d exp %0d", c, bus.res_addr_o, er[c]); end
      end
      tick();
    end
    // start together with abort in IDLE: must stay idle
    drive(1, 1, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    vec_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL abort_start busy got %0b exp 0", bus.busy_o); end
    tick(); tick();
  endtask

  task automatic test_start_ignored();
    bit eb[12] = '{0,1,1,1,1,1,1,1,0,0,0,0};
    bit ed[12] = '{0,0,0,0,0,0,0,0,1,0,0,0};
    int done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      drive(c == 0 || c == 3 || c == 8, 0, 1, c);
      if (bus.done_o === 1'b1) done_seen++;
      vec_cnt++; if (bus.busy_o !== eb[c]) begin err_cnt++; $display("FAIL restart busy c%0d got %0b exp %0b", c, bus.busy_o, eb[c]); end
      vec_cnt++; if (bus.done_o !== ed[c]) begin err_cnt++; $display("FAIL restart done c%0d got %0b exp %0b", c, bus.done_o, ed[c]); end
      tick();
    end
    vec_cnt++; if (done_seen != 1) begin err_cnt++; $display("FAIL restart done_count got %0d exp 1", done_seen); end
  endtask

  task automatic test_reset_midrun();
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, 0, 1, c);
      tick();
    end
    drive(0, 0, 1, 3);
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL midrst busy got %0b exp 0", bus.busy_o); end
    vec_cnt++; if (bus.pe_ce_o !== 1'b0) begin err_cnt++; $display("FAIL midrst pe_ce got %0b exp 0", bus.pe_ce_o); end
    vec_cnt++; if (bus.wt_addr_o !== 2'd0) begin err_cnt++; $display("FAIL midrst wt_addr got %0d exp 0", bus.wt_addr_o); end
    vec_cnt++; if (bus.res_we_o !== 1'b0) begin err_cnt++; $display("FAIL midrst res_we got %0b exp 0", bus.res_we_o); end
    vec_cnt++; if (bus.done_o !== 1'b0) begin err_cnt++; $display("FAIL midrst done got %0b exp 0", bus.done_o); end
    #1 rst_n = 1'b1;
    tick();
    for (int c = 0; c < 7; c++) begin
      drive(0, 0, 1, c);
      vec_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_after busy c%0d got %0b exp 0", c, bus.busy_o); end
      vec_cnt++; if (bus.res_we_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_after res_we c%0d got %0b exp 0", c, bus.res_we_o); end
      vec_cnt++; if (bus.done_o !== 1'b0) begin err_cnt++; $display("FAIL midrst_after done c%0d got %0b exp 0", c, bus.done_o); end
      tick();
    end
  endtask

`ifdef PESCHED_CYCCNT_EN
  task automatic test_cyccnt();
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 0, 1, c);
      tick();
    end
    drive(0, 0, 1, 9);
    vec_cnt++; if (cyc_cnt !== 16'd7) begin err_cnt++; $display("FAIL cyccnt run got %0d exp 7", cyc_cnt); end
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    vec_cnt++; if (cyc_cnt !== 16'd0) begin err_cnt++; $display("FAIL cyccnt clear got %0d exp 0", cyc_cnt); end
    for (int c = 0; c < 70000; c++) tick();
    vec_cnt++; if (cyc_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL cyccnt sat got %h exp ffff", cyc_cnt); end
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    vec_cnt++; if (bus.busy_o !== 1'b0) begin err_cnt++; $display("FAIL cyccnt abort busy got %0b exp 0", bus.busy_o); end
    vec_cnt++; if (cyc_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL cyccnt hold got %h exp ffff", cyc_cnt); end
  endtask
`endif

  initial begin
    bus.start_i  = 1'b0;
    bus.abort_i  = 1'b0;
    bus.wt_rdy_i = 1'b0;
    bus.pe_q_i   = '0;
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_basic();
    test_start_ignored();
    test_reset_midrun();
`ifdef PESCHED_CYCCNT_EN
    test_cyccnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
